// File: rtl/uvmt_apb_st_proto_chkr.sv
// Passive APB3/APB4 protocol checker: tracks each transfer with a phase FSM and reports
// violations as sticky flags, a one-cycle pulse and code, plus transfer/wait statistics.
module uvmt_apb_st_proto_chkr #(
    parameter int unsigned NUM_SLV    = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chk_en,
    input  logic                  clr,
    input  logic [NUM_SLV-1:0]    psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    input  logic [2:0]            pprot,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [7:0]            err_flags,
    output logic                  err_pulse,
    output logic [2:0]            err_code,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic [CNT_WIDTH-1:0]  slverr_cnt,
    output logic [7:0]            last_wait
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic                  unstable_seen_q, unstable_seen_d;
    logic [NUM_SLV-1:0]    psel_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;
    logic [2:0]            pprot_q;

    logic [7:0]            viol;
    logic                  capture, complete, in_access, sel_any, multi_sel, fields_differ;
    logic [7:0]            wait_cur, wait_inc;
    logic [7:0]            err_flags_d, last_wait_d;
    logic                  err_pulse_d;
    logic [2:0]            err_code_d;
    logic [CNT_WIDTH-1:0]  xfer_cnt_d, slverr_cnt_d;

    assign sel_any   = |psel;
    assign multi_sel = (psel & (psel - NUM_SLV'(1))) != '0;
    assign fields_differ = (psel != psel_q) || (paddr != paddr_q) || (pwrite != pwrite_q) ||
                           (pprot != pprot_q) ||
                           (pwrite_q && ((pwdata != pwdata_q) || (pstrb != pstrb_q)));
    // The first PENABLE cycle is evaluated in SETUP, so waits count from zero there.
    assign wait_cur = (state_q == ST_ACCESS) ? wait_q : 8'd0;
    assign wait_inc = (wait_cur == 8'hFF) ? wait_cur : wait_cur + 8'd1;

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        unstable_seen_d = unstable_seen_q;
        viol            = '0;
        capture         = 1'b0;
        complete        = 1'b0;
        in_access       = 1'b0;
        if (!chk_en) begin
            state_d = ST_IDLE;
        end else begin
            viol[0] = multi_sel;
            case (state_q)
                ST_IDLE: begin
                    if (sel_any && penable) begin
                        viol[1] = 1'b1;
                    end else if (sel_any) begin
                        capture = 1'b1;
                    end
                end
                ST_SETUP: begin
                    if ((psel == psel_q) && penable) begin
                        in_access = 1'b1;
                    end else begin
                        viol[2] = sel_any;
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!sel_any || !penable) begin
                        viol[7] = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        in_access = 1'b1;
                    end
                end
                default: begin
                    if (penable) begin
                        viol[5] = 1'b1;
                        state_d = ST_IDLE;
                    end else if (sel_any) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
            if (in_access) begin
                if (fields_differ && !unstable_seen_q) begin
                    viol[3]         = 1'b1;
                    unstable_seen_d = 1'b1;
                end
                if (pready) begin
                    complete = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    wait_d  = wait_inc;
                    state_d = ST_ACCESS;
                    viol[4] = (wait_inc == 8'(MAX_WAIT)) && (wait_inc != wait_cur);
                end
            end
            if (capture) begin
                viol[6]         = !pwrite && (pstrb != '0);
                unstable_seen_d = 1'b0;
                state_d         = ST_SETUP;
            end
        end
    end

    // Clear is applied first so a violation in the clearing cycle still lands.
    always_comb begin
        err_flags_d  = (clr ? 8'd0 : err_flags) | viol;
        err_pulse_d  = |viol;
        err_code_d   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (viol[i]) err_code_d = 3'(i);
        end
        xfer_cnt_d   = clr ? '0 : xfer_cnt;
        last_wait_d  = clr ? 8'd0 : last_wait;
        slverr_cnt_d = slverr_cnt;
        if (complete) begin
            last_wait_d = wait_cur;
            if (xfer_cnt_d != '1) xfer_cnt_d = xfer_cnt_d + CNT_WIDTH'(1);
            if (pslverr && (slverr_cnt != '1)) slverr_cnt_d = slverr_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wait_q          <= 8'd0;
            unstable_seen_q <= 1'b0;
            psel_q          <= '0;
            pwrite_q        <= 1'b0;
            paddr_q         <= '0;
            pwdata_q        <= '0;
            pstrb_q         <= '0;
            pprot_q         <= 3'd0;
            err_flags       <= 8'd0;
            err_pulse       <= 1'b0;
            err_code        <= 3'd0;
            xfer_cnt        <= '0;
            slverr_cnt      <= '0;
            last_wait       <= 8'd0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            unstable_seen_q <= unstable_seen_d;
            if (capture) begin
                psel_q   <= psel;
                pwrite_q <= pwrite;
                paddr_q  <= paddr;
                pwdata_q <= pwdata;
                pstrb_q  <= pstrb;
                pprot_q  <= pprot;
            end
            err_flags  <= err_flags_d;
            err_pulse  <= err_pulse_d;
            err_code   <= err_code_d;
            xfer_cnt   <= xfer_cnt_d;
            slverr_cnt <= slverr_cnt_d;
            last_wait  <= last_wait_d;
        end
    end

endmodule

// File: tb/tb_uvmt_apb_st_proto_chkr.sv
// Directed bench for uvmt_apb_st_proto_chkr: one task per scenario with hand-computed results.
module tb_uvmt_apb_st_proto_chkr;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chk_en = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [7:0]  err_flags;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic [1:0]  xfer_cnt;
    logic [1:0]  slverr_cnt;
    logic [7:0]  last_wait;

    int tests = 0;
    int failed = 0;

    uvmt_apb_st_proto_chkr #(
        .NUM_SLV(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset), .chk_en(chk_en), .clr(clr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .err_flags(err_flags), .err_pulse(err_pulse),
        .err_code(err_code), .xfer_cnt(xfer_cnt), .slverr_cnt(slverr_cnt), .last_wait(last_wait)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [3:0] s, input logic en, input logic rdy);
        psel = s; penable = en; pready = rdy;
        tick();
    endtask

    task automatic set_fields(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] st);
        pwrite = w; paddr = a; pwdata = d; pstrb = st;
    endtask

    task automatic do_reset();
        reset = 1'b1; chk_en = 1'b1; clr = 1'b0; pslverr = 1'b0;
        psel = '0; penable = 1'b0; pready = 1'b0;
        set_fields(1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; psel = 4'b0001; penable = 1'b1; pready = 1'b1;
        tick();
        tests++; if (err_flags !== 8'h00) begin failed++; $display("FAIL reset_flags: got %h want 00", err_flags); end
        tests++; if (err_pulse !== 1'b0) begin failed++; $display("FAIL reset_pulse: got %b want 0", err_pulse); end
        tests++; if (err_code !== 3'd0) begin failed++; $display("FAIL reset_code: got %0d want 0", err_code); end
        tests++; if (xfer_cnt !== 2'd0) begin failed++; $display("FAIL reset_xfer: got %0d want 0", xfer_cnt); end
        tests++; if (slverr_cnt !== 2'd0) begin failed++; $display("FAIL reset_slverr: got %0d want 0", slverr_cnt); end
        tests++; if (last_wait !== 8'd0) begin failed++; $display("FAIL reset_last_wait: got %0d want 0", last_wait); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_fields(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b0);
        bus(4'b0001, 1'b1, 1'b0);
        bus(4'b0001, 1'b1, 1'b1);
        tests++; if (xfer_cnt !== 2'd1) begin failed++; $display("FAIL b2b_xfer1: got %0d want 1", xfer_cnt); end
        tests++; if (last_wait !== 8'd2) begin failed++; $display("FAIL b2b_wait1: got %0d want 2", last_wait); end
        set_fields(1'b0, 32'h80, 32'h0, 4'h0);
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b1);
        bus(4'b0000, 1'b0, 1'b0);
        tests++; if (xfer_cnt !== 2'd2) begin failed++; $display("FAIL b2b_xfer2: got %0d want 2", xfer_cnt); end
        tests++; if (last_wait !== 8'd0) begin failed++; $display("FAIL b2b_wait2: got %0d want 0", last_wait); end
        tests++; if (err_flags !== 8'h00) begin failed++; $display("FAIL b2b_flags: got %h want 00", err_flags); end
    endtask

    task automatic test_penable();
        do_reset();
        set_fields(1'b1, 32'h10, 32'h1, 4'h1);
        bus(4'b0001, 1'b1, 1'b0);
        tests++; if (err_pulse !== 1'b1) begin failed++; $display("FAIL early_pulse: got %b want 1", err_pulse); end
        tests++; if (err_code !== 3'd1) begin failed++; $display("FAIL early_code: got %0d want 1", err_code); end
        tests++; if (err_flags !== 8'h02) begin failed++; $display("FAIL early_flags: got %h want 02", err_flags); end
        bus(4'b0000, 1'b0, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin failed++; $display("FAIL early_pulse_drop: got %b want 0", err_pulse); end
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b1);
        bus(4'b0001, 1'b1, 1'b0);
        tests++; if (err_code !== 3'd5) begin failed++; $display("FAIL stuck_code: got %0d want 5", err_code); end
        tests++; if (err_flags !== 8'h22) begin failed++; $display("FAIL stuck_flags: got %h want 22", err_flags); end
        tests++; if (xfer_cnt !== 2'd1) begin failed++; $display("FAIL stuck_xfer: got %0d want 1", xfer_cnt); end
        bus(4'b0000, 1'b0, 1'b0);
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b0, 1'b0);
        tests++; if (err_code !== 3'd2) begin failed++; $display("FAIL missing_code: got %0d want 2", err_code); end
        tests++; if (err_flags !== 8'h26) begin failed++; $display("FAIL missing_flags: got %h want 26", err_flags); end
        bus(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_unstable();
        do_reset();
        set_fields(1'b1, 32'h40, 32'h55, 4'hF);
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b0);
        paddr = 32'h44;
        bus(4'b0001, 1'b1, 1'b0);
        tests++; if (err_pulse !== 1'b1) begin failed++; $display("FAIL unstable_pulse: got %b want 1", err_pulse); end
        tests++; if (err_code !== 3'd3) begin failed++; $display("FAIL unstable_code: got %0d want 3", err_code); end
        bus(4'b0001, 1'b1, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin failed++; $display("FAIL unstable_once: got %b want 0", err_pulse); end
        bus(4'b0001, 1'b1, 1'b1);
        tests++; if (xfer_cnt !== 2'd1) begin failed++; $display("FAIL unstable_xfer: got %0d want 1", xfer_cnt); end
        tests++; if (err_flags !== 8'h08) begin failed++; $display("FAIL unstable_flags: got %h want 08", err_flags); end
        tests++; if (last_wait !== 8'd3) begin failed++; $display("FAIL unstable_wait: got %0d want 3", last_wait); end
        bus(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        set_fields(1'b0, 32'h100, 32'h0, 4'h0);
        bus(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus(4'b0010, 1'b1, 1'b0);
            tests++;
            if (err_pulse !== (i == 3)) begin
                failed++;
                $display("FAIL timeout_pulse[%0d]: got %b want %b", i, err_pulse, (i == 3));
            end
            if (i == 3) begin
                tests++; if (err_code !== 3'd4) begin failed++; $display("FAIL timeout_code: got %0d want 4", err_code); end
            end
        end
        bus(4'b0010, 1'b1, 1'b1);
        tests++; if (last_wait !== 8'd10) begin failed++; $display("FAIL timeout_wait: got %0d want 10", last_wait); end
        tests++; if (err_flags !== 8'h10) begin failed++; $display("FAIL timeout_flags: got %h want 10", err_flags); end
        bus(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_sel_strb();
        do_reset();
        set_fields(1'b0, 32'h0, 32'h0, 4'hF);
        bus(4'b0110, 1'b0, 1'b0);
        tests++; if (err_flags !== 8'h41) begin failed++; $display("FAIL selstrb_flags: got %h want 41", err_flags); end
        tests++; if (err_code !== 3'd0) begin failed++; $display("FAIL selstrb_code: got %0d want 0", err_code); end
        tests++; if (err_pulse !== 1'b1) begin failed++; $display("FAIL selstrb_pulse: got %b want 1", err_pulse); end
        bus(4'b0000, 1'b0, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin failed++; $display("FAIL selstrb_quiet: got %b want 0", err_pulse); end
    endtask

    task automatic test_clear();
        do_reset();
        set_fields(1'b1, 32'h20, 32'h7, 4'h3);
        bus(4'b0001, 1'b1, 1'b0);
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b0);
        bus(4'b0001, 1'b1, 1'b1);
        tests++; if (last_wait !== 8'd1) begin failed++; $display("FAIL clear_pre_wait: got %0d want 1", last_wait); end
        bus(4'b0000, 1'b0, 1'b0);
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b0);
        clr = 1'b1;
        bus(4'b0000, 1'b0, 1'b0);
        clr = 1'b0;
        tests++; if (err_flags !== 8'h80) begin failed++; $display("FAIL clear_flags: got %h want 80", err_flags); end
        tests++; if (err_code !== 3'd7) begin failed++; $display("FAIL clear_code: got %0d want 7", err_code); end
        tests++; if (xfer_cnt !== 2'd0) begin failed++; $display("FAIL clear_xfer: got %0d want 0", xfer_cnt); end
        tests++; if (last_wait !== 8'd0) begin failed++; $display("FAIL clear_wait: got %0d want 0", last_wait); end
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b1);
        bus(4'b0001, 1'b0, 1'b0);
        psel = 4'b0001; penable = 1'b1; pready = 1'b0;
        reset = 1'b1;
        #2;
        tests++; if (err_flags !== 8'h00) begin failed++; $display("FAIL async_flags: got %h want 00", err_flags); end
        tests++; if (err_code !== 3'd0) begin failed++; $display("FAIL async_code: got %0d want 0", err_code); end
        tests++; if (xfer_cnt !== 2'd0) begin failed++; $display("FAIL async_xfer: got %0d want 0", xfer_cnt); end
        reset = 1'b0;
        tick();
        tests++; if (err_code !== 3'd1) begin failed++; $display("FAIL post_reset_code: got %0d want 1", err_code); end
        tests++; if (err_flags !== 8'h02) begin failed++; $display("FAIL post_reset_flags: got %h want 02", err_flags); end
        bus(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_counters();
        do_reset();
        set_fields(1'b0, 32'h8, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            pslverr = (i == 1) || (i == 3);
            bus(4'b1000, 1'b0, 1'b0);
            bus(4'b1000, 1'b1, 1'b1);
            pslverr = 1'b0;
            bus(4'b0000, 1'b0, 1'b0);
        end
        tests++; if (xfer_cnt !== 2'd3) begin failed++; $display("FAIL sat_xfer: got %0d want 3", xfer_cnt); end
        tests++; if (slverr_cnt !== 2'd2) begin failed++; $display("FAIL sat_slverr: got %0d want 2", slverr_cnt); end
    endtask

    task automatic test_chk_en();
        do_reset();
        set_fields(1'b1, 32'h30, 32'h9, 4'hF);
        bus(4'b0001, 1'b0, 1'b0);
        bus(4'b0001, 1'b1, 1'b0);
        chk_en = 1'b0;
        bus(4'b0000, 1'b0, 1'b0);
        tests++; if (err_flags !== 8'h00) begin failed++; $display("FAIL chken_flags: got %h want 00", err_flags); end
        chk_en = 1'b1;
        bus(4'b0001, 1'b1, 1'b0);
        tests++; if (err_code !== 3'd1) begin failed++; $display("FAIL chken_idle_code: got %0d want 1", err_code); end
        bus(4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_penable();
        test_unstable();
        test_timeout();
        test_sel_strb();
        test_clear();
        test_counters();
        test_chk_en();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
